// File: rtl/cd_pkg.sv
// Shared definitions for the bus deserializer and serializer: CRC constants,
// one-hot receive FSM encodings and the default idle gap length.
package cd_pkg;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'hA001;

  localparam logic [7:0] IDLE_LEN_DEFAULT = 8'd10;

  typedef enum logic [4:0] {
    ST_WAIT_IDLE = 5'b00001,
    ST_IDLE      = 5'b00010,
    ST_START     = 5'b00100,
    ST_DATA      = 5'b01000,
    ST_STOP      = 5'b10000
  } rx_state_t;

endpackage

// File: rtl/crc16_byte.sv
// Combinational byte-wise Modbus CRC16 update (reflected polynomial, LSB first).
// Shared with the transmit serializer.
module crc16_byte
  import cd_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  // Fold the byte into the low CRC bits, then run eight reflected shift steps.
  always_comb begin
    crc_out = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0]) crc_out = (crc_out >> 1) ^ CRC16_POLY;
      else            crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/rx_des.sv
// UART-style 8N1 bit deserializer feeding rx_bytes. Oversamples the
// synchronized line, keeps a running Modbus CRC16 per frame and flags bus
// idle after idle_len quiet bit times.
// Optional: define RX_GLITCH_FILTER_EN to insert a 3-tap majority filter on
// the synchronized line (two extra cycles of latency, rejects 1-cycle pulses).
module rx_des
  import cd_pkg::*;
#(
  parameter int DIV_LS_W = 16,
  parameter int IDLE_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  input  logic [DIV_LS_W-1:0] div_ls,
  input  logic [IDLE_W-1:0]   idle_len,
  input  logic                force_wait_idle,
  output logic                bus_idle,
  output logic [7:0]          data,
  output logic [15:0]         crc_data,
  output logic                data_clk,
  output logic                frame_err
);

  logic rx_m;
  logic rx_s;
  logic rx_l;
  logic rx_prev;
  logic fall;

  logic [DIV_LS_W-1:0] div_cnt;
  logic                bit_tick;

  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_inc;
  logic [IDLE_W-1:0] idle_thr;
  logic              idle_partial;

  rx_state_t  state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [15:0] crc_next;

  // Two-flop synchronizer; idles high so reset does not fake a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef RX_GLITCH_FILTER_EN
  logic tap1;
  logic tap2;
  logic rx_f;

  // Majority of the last three synchronized samples, registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap1 <= 1'b1;
      tap2 <= 1'b1;
      rx_f <= 1'b1;
    end else begin
      tap1 <= rx_s;
      tap2 <= tap1;
      rx_f <= (rx_s & tap1) | (rx_s & tap2) | (tap1 & tap2);
    end
  end

  assign rx_l = rx_f;
`else
  assign rx_l = rx_s;
`endif

  // Previous line level for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_prev <= 1'b1;
    else       rx_prev <= rx_l;
  end

  assign fall     = rx_prev & ~rx_l;
  assign bit_tick = (div_cnt == div_ls);
  assign idle_inc = idle_cnt + 1'b1;
  assign idle_thr = (idle_len == '0) ? IDLE_W'(1) : idle_len;

  // Idle gap counter: counts whole high bit times; the first tick after the
  // line rises covers only a partial bit and is skipped, so bus_idle can never
  // coincide with the data_clk of the stop-bit midpoint.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt     <= '0;
      idle_partial <= 1'b0;
      bus_idle     <= 1'b0;
    end else if (force_wait_idle || !rx_l) begin
      idle_cnt     <= '0;
      idle_partial <= 1'b1;
      bus_idle     <= 1'b0;
    end else if (bit_tick && idle_partial) begin
      idle_partial <= 1'b0;
      bus_idle     <= (idle_cnt >= idle_thr);
    end else if (bit_tick && (idle_cnt < idle_thr)) begin
      idle_cnt <= idle_inc;
      bus_idle <= (idle_inc >= idle_thr);
    end else begin
      bus_idle <= (idle_cnt >= idle_thr);
    end
  end

  crc16_byte u_crc (
    .crc_in  (crc_data),
    .byte_in (shift),
    .crc_out (crc_next)
  );

  // Receive FSM with bit timer, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_WAIT_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      crc_data  <= CRC16_INIT;
      data_clk  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      data_clk  <= 1'b0;
      frame_err <= 1'b0;
      div_cnt   <= bit_tick ? '0 : div_cnt + 1'b1;
      if (bus_idle) crc_data <= CRC16_INIT;

      if (force_wait_idle) begin
        state <= ST_WAIT_IDLE;
      end else begin
        case (state)
          ST_WAIT_IDLE: begin
            if (bus_idle) state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (fall) begin
              div_cnt <= '0;
              state   <= ST_START;
            end
          end
          ST_START: begin
            if (div_cnt == (div_ls >> 1)) begin
              if (rx_l) begin
                state <= ST_IDLE;
              end else begin
                div_cnt <= '0;
                bit_cnt <= '0;
                state   <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (bit_tick) begin
              shift   <= {rx_l, shift[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (bit_tick) begin
              if (rx_l) begin
                data     <= shift;
                crc_data <= crc_next;
                data_clk <= 1'b1;
                state    <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_WAIT_IDLE;
              end
            end
          end
          default: state <= ST_WAIT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_des.sv
// Directed bench for rx_des: idle detection after reset, single byte CRC,
// Modbus frame residue, framing error recovery, force_wait_idle, glitch
// rejection, idle_len=0 handling and asynchronous reset mid-byte.
// Honours RX_GLITCH_FILTER_EN for the glitch expectations.
module tb_rx_des;

  logic        clk;
  logic        reset;
  logic        rx;
  logic [15:0] div_ls;
  logic [7:0]  idle_len;
  logic        force_wait_idle;
  logic        bus_idle;
  logic [7:0]  data;
  logic [15:0] crc_data;
  logic        data_clk;
  logic        frame_err;

  int checks;
  int errors;
  int dc_count;
  int fe_count;
  int overlap_count;
  logic [7:0]  last_data;
  logic [15:0] last_crc;

  rx_des #(.DIV_LS_W(16), .IDLE_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx              (rx),
    .div_ls          (div_ls),
    .idle_len        (idle_len),
    .force_wait_idle (force_wait_idle),
    .bus_idle        (bus_idle),
    .data            (data),
    .crc_data        (crc_data),
    .data_clk        (data_clk),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record output pulses away from the active edge.
  always @(negedge clk) begin
    if (data_clk) begin
      dc_count++;
      last_data = data;
      last_crc  = crc_data;
      if (bus_idle) overlap_count++;
    end
    if (frame_err) fe_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] crcModel(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  task automatic sendBit(input logic b, input logic pulse);
    rx = b;
    if (pulse) begin
      repeat (2) @(negedge clk);
      force_wait_idle = 1'b1;
      @(negedge clk);
      force_wait_idle = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic idleBits(input int n);
    rx = 1'b1;
    repeat (4 * n) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, stop bit; optional force pulse on a data bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int force_bit);
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i], (i == force_bit));
    sendBit(stop_bit, 1'b0);
  endtask

  initial begin
    logic [15:0] fcrc;
    int dc0;
    int fe0;

    checks = 0; errors = 0; dc_count = 0; fe_count = 0; overlap_count = 0;
    last_data = '0; last_crc = '0;
    reset = 1'b1; rx = 1'b1; div_ls = 16'd3; idle_len = 8'd10; force_wait_idle = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_bus_idle", {31'd0, bus_idle}, 32'd0);
    checkOutput("rst_data", {24'd0, data}, 32'd0);
    checkOutput("rst_crc", {16'd0, crc_data}, 32'h0000FFFF);
    checkOutput("rst_data_clk", {31'd0, data_clk}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;

    repeat (30) @(negedge clk);
    checkOutput("idle_not_yet", {31'd0, bus_idle}, 32'd0);
    repeat (15) @(negedge clk);
    checkOutput("idle_after_40", {31'd0, bus_idle}, 32'd1);
    checkOutput("idle_crc", {16'd0, crc_data}, 32'h0000FFFF);

    // Single byte A5
    applyStimulus(8'hA5, 1'b1, -1);
    idleBits(2);
    checkOutput("a5_count", dc_count, 32'd1);
    checkOutput("a5_data", {24'd0, last_data}, 32'h000000A5);
    checkOutput("a5_crc", {16'd0, last_crc}, 32'h00003B7F);
    checkOutput("a5_idle_low", {31'd0, bus_idle}, 32'd0);
    idleBits(12);
    checkOutput("a5_idle_back", {31'd0, bus_idle}, 32'd1);
    checkOutput("a5_crc_reload", {16'd0, crc_data}, 32'h0000FFFF);

    // Frame 01 02 00 + CRC (low, high) gives zero residue
    fcrc = crcModel(crcModel(crcModel(16'hFFFF, 8'h01), 8'h02), 8'h00);
    applyStimulus(8'h01, 1'b1, -1);
    applyStimulus(8'h02, 1'b1, -1);
    applyStimulus(8'h00, 1'b1, -1);
    applyStimulus(fcrc[7:0], 1'b1, -1);
    applyStimulus(fcrc[15:8], 1'b1, -1);
    idleBits(2);
    checkOutput("frame_count", dc_count, 32'd6);
    checkOutput("frame_last", {24'd0, last_data}, {24'd0, fcrc[15:8]});
    checkOutput("frame_residue", {16'd0, last_crc}, 32'd0);
    idleBits(12);

    // Framing error, following byte ignored until idle gap
    applyStimulus(8'h3C, 1'b0, -1);
    idleBits(1);
    applyStimulus(8'h55, 1'b1, -1);
    idleBits(2);
    checkOutput("ferr_pulse", fe_count, 32'd1);
    checkOutput("ferr_no_dc", dc_count, 32'd6);
    idleBits(12);
    checkOutput("ferr_idle", {31'd0, bus_idle}, 32'd1);
    applyStimulus(8'h55, 1'b1, -1);
    idleBits(2);
    checkOutput("ferr_recover", dc_count, 32'd7);
    checkOutput("ferr_rec_data", {24'd0, last_data}, 32'h00000055);
    idleBits(12);

    // force_wait_idle while idle drops bus_idle next cycle, full gap needed
    checkOutput("fwi_pre_idle", {31'd0, bus_idle}, 32'd1);
    force_wait_idle = 1'b1;
    @(negedge clk);
    force_wait_idle = 1'b0;
    checkOutput("fwi_idle_drop", {31'd0, bus_idle}, 32'd0);
    idleBits(5);
    checkOutput("fwi_idle_wait", {31'd0, bus_idle}, 32'd0);
    idleBits(7);
    checkOutput("fwi_idle_back", {31'd0, bus_idle}, 32'd1);

    // force_wait_idle during bit 4 discards the byte
    applyStimulus(8'hF0, 1'b1, 4);
    idleBits(2);
    checkOutput("fwi_byte_drop", dc_count, 32'd7);
    checkOutput("fwi_byte_idle", {31'd0, bus_idle}, 32'd0);
    idleBits(10);
    checkOutput("fwi_byte_idle2", {31'd0, bus_idle}, 32'd1);

    // One-clock low glitch on the idle line
    dc0 = dc_count; fe0 = fe_count;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    idleBits(1);
`ifdef RX_GLITCH_FILTER_EN
    checkOutput("glitch_idle", {31'd0, bus_idle}, 32'd1);
`else
    checkOutput("glitch_idle", {31'd0, bus_idle}, 32'd0);
`endif
    idleBits(3);
    checkOutput("glitch_no_dc", dc_count, dc0);
    checkOutput("glitch_no_fe", fe_count, fe0);
    idleBits(12);
    applyStimulus(8'h81, 1'b1, -1);
    idleBits(2);
    checkOutput("glitch_after", dc_count, dc0 + 1);
    checkOutput("glitch_data", {24'd0, last_data}, 32'h00000081);
    idleBits(12);

    // idle_len = 0 behaves as 1
    idle_len = 8'd0;
    applyStimulus(8'h40, 1'b1, -1);
    idleBits(3);
    checkOutput("len0_data", {24'd0, last_data}, 32'h00000040);
    checkOutput("len0_idle", {31'd0, bus_idle}, 32'd1);
    checkOutput("len0_crc", {16'd0, crc_data}, 32'h0000FFFF);
    idle_len = 8'd10;
    idleBits(12);

    // Asynchronous reset mid-byte
    rx = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_data", {24'd0, data}, 32'd0);
    checkOutput("arst_crc", {16'd0, crc_data}, 32'h0000FFFF);
    checkOutput("arst_idle", {31'd0, bus_idle}, 32'd0);
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dc0 = dc_count;
    idleBits(12);
    applyStimulus(8'h7E, 1'b1, -1);
    idleBits(2);
    checkOutput("arst_recover", dc_count, dc0 + 1);
    checkOutput("arst_rec_data", {24'd0, last_data}, 32'h0000007E);

    checkOutput("no_overlap", overlap_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/rx_des.md
Name: rx_des

Overview:
- UART-style bit deserializer directly upstream of rx_bytes.
- Oversamples the synchronized bus line and recovers 8N1 bytes (LSB first).
- Keeps a running Modbus CRC16 per frame and reports bus idle after a programmable idle gap.
- Drives rx_bytes via bus_idle, data, crc_data, data_clk; honours rx_bytes' force_wait_idle.

Parameters:
- DIV_LS_W, 16, width of bit-period divider.
- IDLE_W, 8, width of idle-length field (in bit times).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  raw bus line, asynchronous to clk; idle level 1.
- div_ls  in  DIV_LS_W  bit period minus 1, in clk cycles; minimum legal value 2.
- idle_len  in  IDLE_W  bus-idle threshold in bit times; 0 treated as 1.
- force_wait_idle  in  1  pulse: abandon current byte and wait for a fresh idle gap.
- bus_idle  out  1  level: line high for at least idle_len bit times.
- data  out  8  last received byte.
- crc_data  out  16  running CRC including data.
- data_clk  out  1  one-cycle pulse: data/crc_data valid.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values:
  - outputs: bus_idle=0, data=0, crc_data=16'hFFFF, data_clk=0, frame_err=0.
  - internal: state=WAIT_IDLE, synchronizer FFs=1.
- Input synchronizer: 2 FF on rx giving rx_s; all logic uses rx_s, 2-cycle input latency.
- Bit timer: div_cnt counts 0..div_ls, then wraps. One bit time = div_ls+1 clk cycles.
- Idle counter:
  - counts bit times while rx_s=1 and clears on rx_s=0.
  - saturates at idle_len.
  - bus_idle=1 while count reaches idle_len, including the cycle it is reached; 0 as soon as rx_s=0.
- CRC:
  - Modbus, reflected poly 16'hA001, init 16'hFFFF.
  - Reloaded to FFFF every cycle bus_idle=1.
  - Updated once per completed byte.
- FSM states: WAIT_IDLE, IDLE, START, DATA, STOP.
- WAIT_IDLE: ignore falling edges; go to IDLE when bus_idle=1.
- IDLE:
  - On a falling edge of rx_s, div_cnt=0 and go to START.
  - A falling edge is also accepted here when bus_idle=0 (inter-byte gap in a frame).
- START:
  - At div_cnt=div_ls/2 (floor), sample rx_s.
  - If 1: glitch, return to IDLE.
  - If 0: reset div_cnt, go to DATA.
- DATA:
  - Sample at mid-bit (div_cnt=div_ls, counted from the start-bit midpoint).
  - Shift in LSB first, 8 bits, bit counter 0..7; then go to STOP.
- STOP:
  - At mid-bit with rx_s=1: data<=shift register, crc_data<=CRC(crc,byte), data_clk=1 for one cycle, go to IDLE.
  - At mid-bit with rx_s=0: frame_err=1, no data_clk, go to WAIT_IDLE.
- Latency: data_clk asserts 1 cycle after the stop-bit mid-sample.
- force_wait_idle wins over all transitions in the same cycle:
  - state<=WAIT_IDLE.
  - Partial byte discarded, no data_clk.
  - Idle counter cleared, so bus_idle drops next cycle and a full idle_len gap must re-elapse.
- Simultaneous data_clk and bus_idle is impossible: bus_idle needs ≥1 bit of high after the stop midpoint.
- The idle counter runs in all states. A frame continuing without an idle gap keeps crc_data accumulating.
- Asynchronous reset mid-byte returns to reset values immediately. The partial byte is lost.

Optional Feature:
- RX_GLITCH_FILTER_EN
  - Defined: rx_s passes through a 3-tap majority filter (2 extra clk latency) before edge detect and sampling. Single-cycle pulses are rejected.
  - Undefined: rx_s is used directly. Minimum legal div_ls is unchanged.

Decomposition:
- Shared package cd_pkg:
  - CRC16_INIT=16'hFFFF, CRC16_POLY=16'hA001.
  - FSM state encodings (one-hot localparams).
  - default idle_len constant 8'd10.
- One sub-module: crc16_byte, a combinational byte-wise CRC update (crc_in, byte_in -> crc_out). Reused by the tx serializer.

Test Plan:
- Reset, div_ls=3, idle_len=10, rx held 1 -> bus_idle rises 40 clk (+2 sync) after reset release; crc_data=FFFF.
- Send byte 8'hA5 with div_ls=3 -> one data_clk, data=A5, crc_data=CRC16(FFFF,A5); bus_idle returns after 10 idle bits.
- Send frame 01 02 00 + Modbus CRC of those 3 bytes (low byte first) -> crc_data=0000 on the 5th data_clk.
- Stop bit forced 0 on byte 8'h3C -> frame_err pulse, no data_clk; next byte is ignored until 10 idle bits elapse.
- force_wait_idle pulse during bit 4 of a byte -> no data_clk for that byte; bus_idle=0 for the next cycle, then a full idle_len gap is required.
- 1-clk low glitch on idle line -> START aborts at the half-bit sample, no data_clk. With RX_GLITCH_FILTER_EN, FSM stays in IDLE.
